// File: rtl/fp_pkg.sv
// Shared FP result-stage definitions: FSM states, bias, NaN/Inf encodings, exception codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int          BIAS      = 127;
  localparam logic [31:0] NAN_CONST = 32'h7FFF_FFFF;
  localparam logic [7:0]  INF_EXP   = 8'hFF;

  // Exception codes, also used by fpdiv
  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_UNDER = 2'b01;
  localparam logic [1:0] EXC_OVER  = 2'b10;
  localparam logic [1:0] EXC_NAN   = 2'b11;

endpackage

// File: rtl/rne_rounder.sv
// Round-to-nearest-even on a 1.23+GRS mantissa, with carry renormalization and field select.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module rne_rounder (
  input  logic               [26:0] mant,
  input  logic                      sticky,
  input  logic signed        [10:0] be,
  output logic               [23:0] m24,
  output logic               [10:0] field,
  output logic                      inexact
);

  logic               lsb;
  logic               g;
  logic               rs;
  logic               up;
  logic        [24:0] sum;
  logic signed [10:0] e_adj;

  // Round, renormalize on carry-out, then pick the biased exponent field
  always_comb begin
    lsb     = mant[3];
    g       = mant[2];
    rs      = mant[1] | mant[0] | sticky;
    up      = g & (rs | lsb);
    inexact = g | rs;
    sum     = {1'b0, mant[26:3]} + {24'd0, up};
    if (sum[24]) begin
      m24   = sum[24:1];
      e_adj = be + 11'sd1;
    end else begin
      m24   = sum[23:0];
      e_adj = be;
    end
    // A denormal that rounds up into the hidden bit becomes the smallest normal
    if (!m24[23])
      field = 11'd0;
    else if (e_adj == 11'sd0)
      field = 11'd1;
    else
      field = e_adj;
  end

endmodule

// File: rtl/fp_round_pack.sv
// Single-precision output stage: denormal align (1 bit/cycle), RNE round, pack, exception code.
// Latency: out_valid 2 edges after accept (accept edge counted), plus one edge per denormal shift.
// Backpressure: result held until out_ready; in_ready only in IDLE, so one op in flight.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int BIAS      = fp_pkg::BIAS,
  parameter int MAX_SHIFT = 25
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [26:0] in_mant,
  input  logic [9:0]  in_exp,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] RESULT,
  output logic [1:0]  EXCEPTION,
  output logic        inexact
);

  state_t             state_q;
  state_t             state_d;
  logic               sign_q;
  logic               nan_q;
  logic               sticky_q;
  logic        [26:0] mant_q;
  logic signed [10:0] be_q;
  logic        [10:0] cnt_q;

  logic signed [10:0] be_in;
  logic        [10:0] cnt_in;
  logic               take_direct;
  logic               take_flush;

  logic        [23:0] rnd_m24;
  logic        [10:0] rnd_field;
  logic               rnd_inexact;

  // 11-bit signed biased exponent never wraps over the full in_exp range
  assign be_in       = {in_exp[9], in_exp} + 11'(BIAS);
  assign cnt_in      = 11'd1 - be_in;
  assign take_direct = in_nan | (be_in > 11'sd0);
  assign take_flush  = !take_direct && (cnt_in > 11'(MAX_SHIFT));

  rne_rounder u_rnd (
    .mant    (mant_q),
    .sticky  (sticky_q),
    .be      (be_q),
    .m24     (rnd_m24),
    .field   (rnd_field),
    .inexact (rnd_inexact)
  );

  // State register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and input handshake
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = (take_direct || take_flush) ? ROUND : SHIFT;
      end
      SHIFT: if (cnt_q == 11'd1) state_d = ROUND;
      ROUND: state_d = HOLD;
      HOLD:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, denormal alignment and registered packed result
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sign_q    <= 1'b0;
      nan_q     <= 1'b0;
      sticky_q  <= 1'b0;
      mant_q    <= 27'd0;
      be_q      <= 11'sd0;
      cnt_q     <= 11'd0;
      out_valid <= 1'b0;
      RESULT    <= 32'd0;
      EXCEPTION <= EXC_NONE;
      inexact   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q   <= in_sign;
          nan_q    <= in_nan;
          sticky_q <= 1'b0;
          cnt_q    <= 11'd0;
          if (take_direct) begin
            mant_q <= in_mant;
            be_q   <= be_in;
          end else if (take_flush) begin
            mant_q   <= 27'd0;
            sticky_q <= |in_mant;
            be_q     <= 11'sd0;
          end else begin
            mant_q <= in_mant;
            be_q   <= 11'sd0;
            cnt_q  <= cnt_in;
          end
        end
        SHIFT: begin
          mant_q   <= mant_q >> 1;
          sticky_q <= sticky_q | mant_q[0];
          cnt_q    <= cnt_q - 11'd1;
        end
        ROUND: begin
          out_valid <= 1'b1;
          inexact   <= rnd_inexact;
          if (nan_q) begin
            RESULT    <= NAN_CONST;
            EXCEPTION <= EXC_NAN;
          end else if (rnd_field >= 11'd255) begin
            RESULT    <= {sign_q, INF_EXP, 23'd0};
            EXCEPTION <= EXC_OVER;
            inexact   <= 1'b1;
          end else if (!rnd_m24[23] && rnd_inexact) begin
            RESULT    <= {sign_q, 8'h00, rnd_m24[22:0]};
            EXCEPTION <= EXC_UNDER;
          end else begin
            RESULT    <= {sign_q, rnd_field[7:0], rnd_m24[22:0]};
            EXCEPTION <= EXC_NONE;
          end
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed cases, handshake/reset scenarios, randomized ops vs a numeric model.
// Latency: measured per op in edges, accept edge counted as edge 1.
// Backpressure: exercised by holding out_ready low and by continuous back-to-back traffic.
module tb_fp_round_pack;

  logic        CLOCK;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [26:0] in_mant;
  logic [9:0]  in_exp;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] RESULT;
  logic [1:0]  EXCEPTION;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  fp_round_pack dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .in_nan    (in_nan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RESULT    (RESULT),
    .EXCEPTION (EXCEPTION),
    .inexact   (inexact)
  );

  // Reference: the quotient is mant * 2^(e-26) with 3 extra low bits; round the value exactly
  function automatic void model(input logic s, input logic [26:0] m, input int e, input logic n,
                                output logic [31:0] r, output logic [1:0] x, output logic ix,
                                output int lat);
    longint q, keep, rem, mask;
    int     be, sh, field;
    bit     st;
    be  = e + 127;
    q   = longint'(m);
    st  = 0;
    lat = 2;
    if (!n && be < 1) begin
      sh = 1 - be;
      if (sh > 25) begin
        st = (m != 0);
        q  = 0;
      end else begin
        mask = (longint'(1) << sh) - 1;
        st   = (q & mask) != 0;
        q    = q >> sh;
        lat  = 2 + sh;
      end
      be = 0;
    end
    keep = q >> 3;
    rem  = (q & 7) * 2 + longint'(st);  // discarded part in 1/16 ulp; 8 is exactly half
    ix   = (rem != 0);
    if (rem > 8 || (rem == 8 && keep[0])) keep = keep + 1;
    if (keep >= (longint'(1) << 24)) begin
      keep = keep >> 1;
      be   = be + 1;
    end
    if (keep >= (longint'(1) << 23)) field = (be < 1) ? 1 : be;
    else                             field = 0;
    if (n) begin
      r = 32'h7FFF_FFFF; x = 2'b11;
    end else if (field >= 255) begin
      r = {s, 8'hFF, 23'd0}; x = 2'b10; ix = 1'b1;
    end else if (field == 0 && ix) begin
      r = {s, 8'h00, 23'(keep)}; x = 2'b01;
    end else begin
      r = {s, 8'(field), 23'(keep)}; x = 2'b00;
    end
  endfunction

  // Drive one op, measure edges to out_valid, capture outputs, then release after hold_cycles
  task automatic do_op(input logic s, input logic [26:0] m, input int e, input logic n,
                       input int hold_cycles, output logic [31:0] r, output logic [1:0] x,
                       output logic ix, output int edges);
    int guard;
    @(negedge CLOCK);
    in_sign   = s;
    in_mant   = m;
    in_exp    = e[9:0];
    in_nan    = n;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge CLOCK);
      guard++;
    end
    @(posedge CLOCK);
    edges = 1;
    #1;
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_mant  = 27'($urandom);
    in_exp   = 10'($urandom);
    in_nan   = 1'($urandom);
    while (!out_valid && edges < 200) begin
      @(posedge CLOCK);
      edges++;
      #1;
    end
    r  = RESULT;
    x  = EXCEPTION;
    ix = inexact;
    repeat (hold_cycles) @(posedge CLOCK);
    @(negedge CLOCK);
    out_ready = 1'b1;
    @(posedge CLOCK);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RESET     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_mant   = 27'd0;
    in_exp    = 10'd0;
    in_nan    = 1'b0;
    out_ready = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (RESULT !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", RESULT); end
    checks++; if (EXCEPTION !== 2'b00) begin errors++; $display("FAIL reset_exception got %b want 00", EXCEPTION); end
    checks++; if (inexact !== 1'b0) begin errors++; $display("FAIL reset_inexact got %b want 0", inexact); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic [26:0] m;
    int          e;
    logic        n;
    logic [31:0] r;
    logic [1:0]  x;
    logic        ix;
    bit          ix_care;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        v[11];
    logic [31:0] r;
    logic [1:0]  x;
    logic        ix;
    int          lat;
    v[0]  = '{1'b0, 27'h4000000,    0, 1'b0, 32'h3F800000, 2'b00, 1'b0, 1'b1, 2};
    v[1]  = '{1'b0, 27'h4000004,    0, 1'b0, 32'h3F800000, 2'b00, 1'b1, 1'b1, 2};
    v[2]  = '{1'b0, 27'h400000C,    0, 1'b0, 32'h3F800002, 2'b00, 1'b1, 1'b1, 2};
    v[3]  = '{1'b0, 27'h4000006,    0, 1'b0, 32'h3F800001, 2'b00, 1'b1, 1'b1, 2};
    v[4]  = '{1'b0, 27'h7FFFFFC,    0, 1'b0, 32'h40000000, 2'b00, 1'b1, 1'b1, 2};
    v[5]  = '{1'b0, 27'h7FFFFFC,  127, 1'b0, 32'h7F800000, 2'b10, 1'b1, 1'b1, 2};
    v[6]  = '{1'b1, 27'h4000000,  128, 1'b0, 32'hFF800000, 2'b10, 1'b1, 1'b1, 2};
    v[7]  = '{1'b0, 27'h4000005,    0, 1'b1, 32'h7FFFFFFF, 2'b11, 1'b0, 1'b0, 2};
    v[8]  = '{1'b0, 27'h4000000, -127, 1'b0, 32'h00400000, 2'b00, 1'b0, 1'b1, 3};
    v[9]  = '{1'b0, 27'h4000001, -127, 1'b0, 32'h00400000, 2'b01, 1'b1, 1'b1, 3};
    v[10] = '{1'b0, 27'h4000000, -160, 1'b0, 32'h00000000, 2'b01, 1'b1, 1'b1, 2};
    foreach (v[i]) begin
      do_op(v[i].s, v[i].m, v[i].e, v[i].n, 0, r, x, ix, lat);
      checks++; if (r !== v[i].r) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, r, v[i].r); end
      checks++; if (x !== v[i].x) begin errors++; $display("FAIL dir%0d_exception got %b want %b", i, x, v[i].x); end
      if (v[i].ix_care) begin
        checks++; if (ix !== v[i].ix) begin errors++; $display("FAIL dir%0d_inexact got %b want %b", i, ix, v[i].ix); end
      end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] er;
    logic [1:0]  ex;
    logic        eix;
    int          el;
    int          guard;
    int          late;
    model(1'b0, 27'h4000004, 5, 1'b0, er, ex, eix, el);
    @(negedge CLOCK);
    in_sign = 1'b0; in_mant = 27'h4000004; in_exp = 10'd5; in_nan = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLOCK);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge CLOCK);
      #1;
      guard++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b want 1", out_valid); end
    checks++; if (RESULT !== er) begin errors++; $display("FAIL hold_result got %h want %h", RESULT, er); end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLOCK);
      in_valid = 1'b1;
      in_mant  = {1'b1, 26'($urandom)};
      in_exp   = 10'($urandom_range(0, 20));
      in_sign  = 1'b1;
      @(posedge CLOCK);
      #1;
      checks++; if (RESULT !== er) begin errors++; $display("FAIL hold_stable%0d got %h want %h", c, RESULT, er); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready%0d got %b want 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid%0d got %b want 1", c, out_valid); end
    end
    @(negedge CLOCK);
    out_ready = 1'b1;
    @(posedge CLOCK);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_idle_ready got %b want 1", in_ready); end
    late = 0;
    repeat (6) begin
      @(posedge CLOCK);
      #1;
      if (out_valid) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL hold_no_accept got %0d valid cycles want 0", late); end
  endtask

  task automatic test_reset_midshift();
    logic [31:0] r, er;
    logic [1:0]  x, ex;
    logic        ix, eix;
    int          lat, el, seen;
    @(negedge CLOCK);
    in_sign = 1'b1; in_mant = 27'h5A5A5A5; in_exp = 10'(-140); in_nan = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLOCK);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_shift_out_valid got %b want 0", out_valid); end
    checks++; if (RESULT !== 32'd0) begin errors++; $display("FAIL rst_shift_result got %h want 00000000", RESULT); end
    checks++; if (EXCEPTION !== 2'b00) begin errors++; $display("FAIL rst_shift_exception got %b want 00", EXCEPTION); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_shift_in_ready got %b want 1", in_ready); end
    @(negedge CLOCK);
    RESET = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge CLOCK);
      #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_shift_discard got %0d valid cycles want 0", seen); end
    model(1'b0, 27'h4C00000, 3, 1'b0, er, ex, eix, el);
    do_op(1'b0, 27'h4C00000, 3, 1'b0, 0, r, x, ix, lat);
    checks++; if (r !== er) begin errors++; $display("FAIL rst_after_result got %h want %h", r, er); end
    checks++; if (lat !== el) begin errors++; $display("FAIL rst_after_latency got %0d want %0d", lat, el); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    logic [1:0]  ex;
    logic        eix;
    int          el, nv;
    logic [26:0] m;
    int          e;
    m = {1'b1, 26'($urandom)};
    e = int'($urandom_range(0, 100)) - 50;
    model(1'b1, m, e, 1'b0, er, ex, eix, el);
    @(negedge CLOCK);
    in_sign = 1'b1; in_mant = m; in_exp = e[9:0]; in_nan = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    nv = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLOCK);
      #1;
      if (out_valid) begin
        nv++;
        checks++; if (RESULT !== er) begin errors++; $display("FAIL b2b_result%0d got %h want %h", i, RESULT, er); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (nv !== 10) begin errors++; $display("FAIL b2b_count got %0d want 10", nv); end
  endtask

  task automatic test_random();
    logic [31:0] r, er;
    logic [1:0]  x, ex;
    logic        ix, eix;
    int          lat, el, sel, e;
    logic        s, n;
    logic [26:0] m;
    for (int k = 0; k < 150; k++) begin
      s   = 1'($urandom);
      m   = {1'b1, 26'($urandom)};
      if ($urandom_range(0, 3) == 0) m[2:0] = 3'b100;
      n   = 1'b0;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      e = int'($urandom_range(0, 260)) - 130;
      else if (sel < 7) e = int'($urandom_range(0, 25)) - 151;
      else if (sel < 8) e = int'($urandom_range(0, 360)) - 512;
      else if (sel < 9) e = int'($urandom_range(0, 391)) + 120;
      else begin
        e = int'($urandom_range(0, 1023)) - 512;
        n = 1'b1;
      end
      model(s, m, e, n, er, ex, eix, el);
      do_op(s, m, e, n, int'($urandom_range(0, 2)), r, x, ix, lat);
      checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_result m=%h e=%0d got %h want %h", k, m, e, r, er); end
      checks++; if (x !== ex) begin errors++; $display("FAIL rnd%0d_exception got %b want %b", k, x, ex); end
      if (!n) begin
        checks++; if (ix !== eix) begin errors++; $display("FAIL rnd%0d_inexact got %b want %b", k, ix, eix); end
      end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", k, lat, el); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_midshift();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Output stage placed directly downstream of the iterative mantissa divider and exponent adder in fpdiv.
- Accepts an unrounded quotient: sign, normalized 1.xxx mantissa with guard/round/sticky bits, and unbiased signed exponent.
- Performs denormal alignment (one bit per cycle), IEEE-754 round-to-nearest-even, and renormalization on rounding carry.
- Packs the 32-bit single-precision result and the 2-bit EXCEPTION code.
- Replaces the ad-hoc normalizer and truncating pack with a valid/ready handshake stage.

Parameters:
- BIAS, 127, exponent bias added to in_exp.
- MAX_SHIFT, 25, alignment shifts beyond this flush the mantissa to zero with sticky set.

Ports:
- CLOCK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream quotient valid.
- in_ready  output  1  stage can accept; high only in IDLE.
- in_sign  input  1  result sign (signA ^ signB).
- in_mant  input  27  bit26 = hidden 1, bits25:3 = fraction, bit2 = G, bit1 = R, bit0 = S.
- in_exp  input  10  signed unbiased exponent (two's complement).
- in_nan  input  1  force canonical NaN.
- out_valid  output  1  RESULT/EXCEPTION valid; held until out_ready.
- out_ready  input  1  downstream accepts.
- RESULT  output  32  packed IEEE-754 single.
- EXCEPTION  output  2  00 none, 01 underflow, 10 overflow, 11 NaN.
- inexact  output  1  any nonzero bit discarded by rounding or flush.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; out_valid = 0; RESULT = 0; EXCEPTION = 00; inexact = 0; internal mantissa, sticky, and counters cleared. An in-flight operation is discarded with no output.
- States: IDLE, SHIFT, ROUND, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid, register sign, mant, nan, and be = in_exp + BIAS as 11-bit signed.
  - If in_nan: go to ROUND.
  - Else if be >= 1: go to ROUND.
  - Else cnt = 1 - be:
    - cnt > MAX_SHIFT: mant := 0, sticky := |in_mant, be := 0, go to ROUND.
    - otherwise: be := 0, go to SHIFT.
- SHIFT:
  - Each cycle: mant >>= 1, sticky |= shifted-out bit, cnt--.
  - After the final shift (cnt reaches 0), go to ROUND.
  - Total cycles spent in SHIFT = original cnt.
- ROUND (one cycle, combinational rounder, registered outputs):
  - lsb = mant[3]; g = mant[2]; rs = mant[1] | mant[0] | sticky.
  - up = g & (rs | lsb).
  - m24 = mant[26:3] + up, computed as 25 bits.
  - If m24[24]: m24 >>= 1, be += 1.
  - Denormal case (be = 0): if m24[23] becomes 1, the exponent field is 1.
  - Exponent field = be if m24[23] = 1, else 0.
  - inexact = g | rs.
  - Priority:
    1. nan: RESULT = 0x7FFFFFFF, EXCEPTION = 11.
    2. Field >= 255: RESULT = {sign, 8'hFF, 23'h0}, EXCEPTION = 10, inexact = 1.
    3. Field = 0 and inexact: RESULT = {sign, 8'h00, m24[22:0]}, EXCEPTION = 01.
    4. Otherwise: RESULT = {sign, field, m24[22:0]}, EXCEPTION = 00.
  - Set out_valid = 1 and go to HOLD.
- HOLD:
  - RESULT, EXCEPTION, and inexact are stable; in_ready = 0.
  - On out_ready: out_valid = 0 on the next edge, go to IDLE.
  - No new input is accepted in the same cycle as the out_ready transfer.
- Latency: out_valid rises 2 edges after the accept edge, plus cnt additional edges on the denormal path. Throughput is 1 operation per (latency + 1) cycles minimum.
- in_valid is ignored outside IDLE. Upstream must hold its inputs only until the accepting edge.
- Width rules:
  - be uses 11-bit signed arithmetic, so no wrap over in_exp range -512..511.
  - Any be >= 255 before rounding goes straight to overflow.

Decomposition:
- Shared package fp_pkg: state enum, BIAS, NAN_CONST = 0x7FFFFFFF, INF exponent 8'hFF, EXCEPTION codes EXC_NONE / EXC_UNDER / EXC_OVER / EXC_NAN. fpdiv is to use the same codes.
- One sub-module, rne_rounder: combinational. Takes mant[26:0], sticky, and be; produces m24, adjusted exponent field, and inexact. It is reusable by a future adder/multiplier.

Test Plan:
1. in_mant = 27'h4000000, in_exp = 0, sign = 0 -> RESULT = 0x3F800000, EXC = 00, inexact = 0; out_valid exactly 2 edges after accept.
2. RNE rounding at exp 0:
   - in_mant = 27'h4000004 (tie, lsb 0) -> 0x3F800000, inexact = 1.
   - in_mant = 27'h400000C (tie, lsb 1) -> 0x3F800002.
   - in_mant = 27'h4000006 (above tie) -> 0x3F800001.
3. Carry renormalization: in_mant = 27'h7FFFFFC, in_exp = 0 -> 0x40000000, EXC = 00. Same mant with in_exp = 127 -> 0x7F800000, EXC = 10.
4. Overflow and NaN:
   - in_exp = 128, sign = 1 -> 0xFF800000, EXC = 10.
   - in_nan = 1 with arbitrary mant -> 0x7FFFFFFF, EXC = 11.
5. Denormals:
   - in_exp = -127, mant = 27'h4000000 -> 0x00400000, EXC = 00, out_valid 3 edges after accept.
   - in_exp = -127, mant = 27'h4000001 -> 0x00400000, EXC = 01.
   - in_exp = -160 -> 0x00000000, EXC = 01, inexact = 1, no SHIFT cycles.
6. Handshake and reset:
   - Hold out_ready = 0 for 5 cycles -> RESULT stable, in_ready = 0, a second in_valid is ignored.
   - Assert RESET during SHIFT (in_exp = -140) -> out_valid = 0 and RESULT = 0 immediately; a subsequent normal op completes correctly.
